// File: rtl/trg_src_sched.sv
// Trigger-source scheduler: edge capture, busy/enable gating, round-robin grant, req/ack handshake, dead time.
// Optional build macro TRG_SRC_STAT_EN adds the saturating dropped-edge counter on drop_cnt_out.
module trg_src_sched #(
  parameter int CNT_W  = 16,
  parameter int DEAD_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              trg_enb_in,
  input  logic [2:0]        src_trg_in,
  input  logic [2:0]        src_mask_in,
  input  logic [1:0]        busy_syn_in,
  input  logic              pmu_busy_in,
  input  logic              busy_ignore_in,
  input  logic [DEAD_W-1:0] trg_dead_time_in,
  input  logic              trg_ack_in,
  output logic              trg_req_out,
  output logic [1:0]        trg_src_out,
  output logic [CNT_W-1:0]  trg_id_out,
  output logic [CNT_W-1:0]  drop_cnt_out,
  input  logic              stat_clr_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         src_q, src_q2;
  logic [2:0]         pend, pend_nxt;
  logic [1:0]         last_grant;
  logic [DEAD_W-1:0]  dead_cnt;

  logic               busy;
  logic [2:0]         rise, set_vec, clr_vec, drop;
  logic               ack_hit;
  logic               grant_vld, do_grant;
  logic [1:0]         grant_idx, cand;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Two-stage source pipeline: an edge seen at edge n lands in pend at n+1.
  always_comb begin
    busy     = (|busy_syn_in | pmu_busy_in) & ~busy_ignore_in;
    rise     = src_q & ~src_q2;
    set_vec  = rise & src_mask_in & {3{trg_enb_in}};
    ack_hit  = (state == REQ) && trg_ack_in;
    clr_vec  = ack_hit ? (3'b001 << trg_src_out) : 3'b000;
    // A fresh edge on the source being acknowledged re-arms it instead of counting as a drop.
    drop     = set_vec & pend & ~clr_vec;
    pend_nxt = trg_enb_in ? ((pend & ~clr_vec) | set_vec) : 3'b000;
  end

  // Round-robin search starting one past the last granted source.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = inc3(last_grant);
    for (int k = 0; k < 3; k++) begin
      if (!grant_vld && pend[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
      cand = inc3(cand);
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    unique case (state)
      IDLE: begin
        if (trg_enb_in && !busy && grant_vld) begin
          do_grant  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (trg_ack_in)       state_nxt = DEAD;
        else if (!trg_enb_in) state_nxt = IDLE;
      end
      DEAD: begin
        if (dead_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= IDLE;
      src_q       <= '0;
      src_q2      <= '0;
      pend        <= '0;
      last_grant  <= 2'd2;
      trg_src_out <= 2'd0;
      dead_cnt    <= '0;
      trg_id_out  <= '0;
    end else begin
      state  <= state_nxt;
      src_q  <= src_trg_in;
      src_q2 <= src_q;
      pend   <= pend_nxt;
      if (do_grant) begin
        trg_src_out <= grant_idx;
        last_grant  <= grant_idx;
      end
      // Dead time is sampled only at ack; later changes do not affect the running period.
      if (ack_hit) begin
        dead_cnt   <= trg_dead_time_in;
        trg_id_out <= trg_id_out + 1'b1;
      end else if (state == DEAD && dead_cnt != '0) begin
        dead_cnt <= dead_cnt - 1'b1;
      end
    end
  end

  assign trg_req_out = (state == REQ);

`ifdef TRG_SRC_STAT_EN
  logic [CNT_W-1:0] drop_cnt;
  logic [1:0]       n_drop;
  logic [CNT_W:0]   drop_sum;

  assign n_drop   = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)              drop_cnt <= '0;
    else if (stat_clr_in)     drop_cnt <= '0;
    else if (drop_sum[CNT_W]) drop_cnt <= '1;
    else                      drop_cnt <= drop_sum[CNT_W-1:0];
  end

  assign drop_cnt_out = drop_cnt;
`else
  logic unused_stat;
  assign unused_stat  = ^{stat_clr_in, drop};
  assign drop_cnt_out = '0;
`endif

endmodule

// File: tb/tb_trg_src_sched.sv
// Directed bench for trg_src_sched; counters narrowed to 8 bits so the ID wrap is reachable in a short run.
module tb_trg_src_sched;
  localparam int CNT_W  = 8;
  localparam int DEAD_W = 8;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              trg_enb_in;
  logic [2:0]        src_trg_in;
  logic [2:0]        src_mask_in;
  logic [1:0]        busy_syn_in;
  logic              pmu_busy_in;
  logic              busy_ignore_in;
  logic [DEAD_W-1:0] trg_dead_time_in;
  logic              trg_ack_in;
  logic              trg_req_out;
  logic [1:0]        trg_src_out;
  logic [CNT_W-1:0]  trg_id_out;
  logic [CNT_W-1:0]  drop_cnt_out;
  logic              stat_clr_in;

  int n_cmp = 0;
  int n_err = 0;
  int got;

  always #5 clk_in = ~clk_in;

  trg_src_sched #(.CNT_W(CNT_W), .DEAD_W(DEAD_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .trg_enb_in      (trg_enb_in),
    .src_trg_in      (src_trg_in),
    .src_mask_in     (src_mask_in),
    .busy_syn_in     (busy_syn_in),
    .pmu_busy_in     (pmu_busy_in),
    .busy_ignore_in  (busy_ignore_in),
    .trg_dead_time_in(trg_dead_time_in),
    .trg_ack_in      (trg_ack_in),
    .trg_req_out     (trg_req_out),
    .trg_src_out     (trg_src_out),
    .trg_id_out      (trg_id_out),
    .drop_cnt_out    (drop_cnt_out),
    .stat_clr_in     (stat_clr_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse(input logic [2:0] s);
    src_trg_in = s;
    tick();
    src_trg_in = 3'b000;
  endtask

  // Acknowledges every request seen while toggling source 0 to keep it re-armed.
  task automatic run_acks(input int need, output int acks);
    int cyc = 0;
    acks = 0;
    while (acks < need && cyc < 3000) begin
      src_trg_in[0] = ~src_trg_in[0];
      if (trg_req_out) begin
        trg_ack_in = 1'b1;
        acks++;
      end else begin
        trg_ack_in = 1'b0;
      end
      tick();
      cyc++;
    end
    trg_ack_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; trg_enb_in = 1'b1; src_trg_in = '0; src_mask_in = 3'b111;
    busy_syn_in = '0; pmu_busy_in = 1'b0; busy_ignore_in = 1'b0;
    trg_dead_time_in = '0; trg_ack_in = 1'b0; stat_clr_in = 1'b0;
    tick(2);
    check("rst_req", trg_req_out, 0);
    check("rst_src", trg_src_out, 0);
    check("rst_id", trg_id_out, 0);
    check("rst_drop", drop_cnt_out, 0);
    rst_in = 1'b1;
    tick();

    // All three sources at once, dead=0, ack held: grants 0,1,2 every third cycle.
    trg_ack_in = 1'b1;
    pulse(3'b111);
    tick(2);
    check("rr0_req", trg_req_out, 1);
    check("rr0_src", trg_src_out, 0);
    tick(3);
    check("rr1_src", trg_src_out, 1);
    tick(3);
    check("rr2_req", trg_req_out, 1);
    check("rr2_src", trg_src_out, 2);
    tick();
    check("rr_id", trg_id_out, 3);
    check("rr_req_off", trg_req_out, 0);
    trg_ack_in = 1'b0;
    tick();

    // Single coincidence pulse, dead=3, ack two cycles after req.
    trg_dead_time_in = 8'd3;
    pulse(3'b001);
    check("lat_n", trg_req_out, 0);
    tick();
    check("lat_n1", trg_req_out, 0);
    tick();
    check("lat_n2", trg_req_out, 1);
    check("lat_src", trg_src_out, 0);
    tick();
    check("req_hold", trg_req_out, 1);
    trg_ack_in = 1'b1;
    tick();
    check("ack_req_off", trg_req_out, 0);
    check("ack_id", trg_id_out, 4);
    trg_ack_in = 1'b0;
    pulse(3'b010);
    tick(3);
    check("dead_block", trg_req_out, 0);
    tick();
    check("dead_release", trg_req_out, 1);
    check("dead_src", trg_src_out, 1);
    trg_ack_in = 1'b1;
    tick();
    check("id5", trg_id_out, 5);
    trg_ack_in = 1'b0;
    trg_dead_time_in = 8'd0;
    tick(5);

    // Busy gating, ignore override, busy clear, busy during REQ.
    pmu_busy_in = 1'b1;
    pulse(3'b010);
    tick(4);
    check("busy_block", trg_req_out, 0);
    busy_ignore_in = 1'b1;
    tick();
    check("busy_ign_req", trg_req_out, 1);
    check("busy_ign_src", trg_src_out, 1);
    busy_ignore_in = 1'b0;
    tick();
    check("busy_in_req", trg_req_out, 1);
    trg_ack_in = 1'b1;
    tick();
    check("id6", trg_id_out, 6);
    trg_ack_in = 1'b0;
    tick();
    pulse(3'b010);
    tick(4);
    check("busy_block2", trg_req_out, 0);
    pmu_busy_in = 1'b0;
    tick();
    check("busy_clr_req", trg_req_out, 1);
    trg_ack_in = 1'b1;
    tick();
    check("id7", trg_id_out, 7);
    trg_ack_in = 1'b0;
    tick();

    // Drop while pending, clear-vs-drop, then set-wins-over-ack on source 2.
    busy_syn_in = 2'b10;
    pulse(3'b100);
    tick();
    pulse(3'b100);
    tick();
`ifdef TRG_SRC_STAT_EN
    check("drop1", drop_cnt_out, 1);
`else
    check("drop_off", drop_cnt_out, 0);
`endif
    pulse(3'b100);
    stat_clr_in = 1'b1;
    tick();
    stat_clr_in = 1'b0;
    check("drop_clr", drop_cnt_out, 0);
    busy_syn_in = 2'b00;
    tick();
    check("src2_req", trg_req_out, 1);
    check("src2_src", trg_src_out, 2);
    src_trg_in = 3'b100;
    tick();
    src_trg_in = 3'b000;
    trg_ack_in = 1'b1;
    tick();
    check("setwin_id", trg_id_out, 8);
    check("setwin_drop", drop_cnt_out, 0);
    trg_ack_in = 1'b0;
    tick(2);
    check("setwin_req", trg_req_out, 1);
    check("setwin_src", trg_src_out, 2);
    trg_ack_in = 1'b1;
    tick();
    trg_ack_in = 1'b0;
    tick();

    // Enable dropped while in REQ: withdraw, keep ID, pending cleared and blocked.
    pulse(3'b001);
    tick(2);
    check("enb_req", trg_req_out, 1);
    trg_enb_in = 1'b0;
    tick();
    check("enb_withdraw", trg_req_out, 0);
    check("enb_id", trg_id_out, 9);
    pulse(3'b010);
    tick();
    trg_enb_in = 1'b1;
    tick(4);
    check("enb_no_pend", trg_req_out, 0);

    // Trigger ID wrap at the counter width.
    run_acks(246, got);
    check("wrap_budget1", got, 246);
    check("id_max", trg_id_out, 8'hFF);
    run_acks(1, got);
    check("id_wrap", trg_id_out, 0);
    trg_dead_time_in = 8'd20;
    run_acks(1, got);
    check("id_after_wrap", trg_id_out, 1);
    src_trg_in = 3'b000;
    tick(2);

    // Asynchronous reset in the middle of the dead period.
    #2 rst_in = 1'b0;
    #1;
    check("arst_req", trg_req_out, 0);
    check("arst_src", trg_src_out, 0);
    check("arst_id", trg_id_out, 0);
    check("arst_drop", drop_cnt_out, 0);
    tick();
    rst_in = 1'b1;
    tick();
    pulse(3'b011);
    tick();
    check("post_rst_n1", trg_req_out, 0);
    tick();
    check("post_rst_req", trg_req_out, 1);
    check("post_rst_src", trg_src_out, 0);
    trg_ack_in = 1'b1;
    tick();
    check("post_rst_id", trg_id_out, 1);
    trg_ack_in = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
